// File: rtl/if_id_buffer.sv
// Instruction fetch-to-decode buffer: a small FIFO of fetched {instr, pc} pairs
// delivered to decode over a 4-phase req/ack handshake, with branch flush support.
module if_id_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 16,
  parameter int unsigned PW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [IW-1:0]            in_instr,
  input  logic [PW-1:0]            in_pc,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     req,
  input  logic                     ack,
  output logic [IW-1:0]            instr_out,
  output logic [PW-1:0]            pc_out,
  output logic                     killed,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  state_t          state_q,  state_d;
  logic            req_q,    req_d;
  logic            killed_q, killed_d;
  entry_t          head_q,   head_d;
  logic            push;
  logic            pop;

  // Readiness is derived from the registered count only; reset masks it.
  assign in_ready  = (count_q < CW'(DEPTH)) && !reset;
  assign push      = in_valid && in_ready && !flush;

  assign req       = req_q;
  assign killed    = killed_q;
  assign instr_out = head_q.instr;
  assign pc_out    = head_q.pc;
  assign count     = count_q;

  // Output handshake FSM; a pop is only launched from IDLE with ack low.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    killed_d = killed_q;
    head_d   = head_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !ack && !flush) begin
          pop      = 1'b1;
          head_d   = mem_q[rd_ptr_q];
          killed_d = 1'b0;
          req_d    = 1'b1;
          state_d  = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end
        if (flush) killed_d = 1'b1;
      end
      REQ_LO: begin
        if (!ack) state_d = IDLE;
        if (flush) killed_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping; flush empties the buffer and rewinds both pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      killed_q <= 1'b0;
      head_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      killed_q <= killed_d;
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: in_instr, pc: in_pc};
  end

endmodule
